// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and frame-length helper for the Clause 22 MDIO engine.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WR    = 2'b10;

  localparam int HEADER_BITS = 14;  // ST + OP + PHYAD + REGAD
  localparam int TA_BITS     = 2;
  localparam int DATA_BITS   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_TURNAROUND,
    S_DATA,
    S_DONE
  } mdio_state_t;

  // Total serial bits in one management frame.
  function automatic int frame_bits(input int preamble_len);
    return preamble_len + HEADER_BITS + TA_BITS + DATA_BITS;
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: MDC_HALF clocks low then MDC_HALF clocks high per bit, with one-cycle
// strobes flagging the edge on which MDC will rise or fall. Held low and cleared while
// run is deasserted, so every frame starts from a fresh low phase.
module mdio_clkgen #(
  parameter int MDC_HALF = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic mdc,
  output logic fall_en,
  output logic rise_en
);

  localparam int DIV_W = $clog2(MDC_HALF + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_HALF - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic             mdc_reg;
  logic             half_done;

  assign half_done = run && (div_cnt_reg == DIV_LAST);
  assign rise_en   = half_done && !mdc_reg;
  assign fall_en   = half_done && mdc_reg;
  assign mdc       = mdc_reg;

  // Half-period counter; toggles MDC at the end of each half period while running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      mdc_reg     <= 1'b0;
    end else if (!run) begin
      div_cnt_reg <= '0;
      mdc_reg     <= 1'b0;
    end else if (half_done) begin
      div_cnt_reg <= '0;
      mdc_reg     <= ~mdc_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO frame engine: accepts one read/write request at a time, serialises it
// onto MDC/MDIO and strobes ready when the frame (or the post-reset start-up) completes.
module mdio_master
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter int         PREAMBLE_LEN = 32,
  parameter int         MDC_HALF     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  addr,
  input  logic        rd_request,
  input  logic        wr_request,
  input  logic [15:0] wr_data,
  output logic        ready,
  output logic [15:0] rd_data,
  inout  wire         mdio_pin,
  output logic        mdc_pin
);

  localparam int N_BITS = frame_bits(PREAMBLE_LEN);
  localparam int CNT_W  = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] LAST_PRE = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(PREAMBLE_LEN + HEADER_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_TA  = CNT_W'(PREAMBLE_LEN + HEADER_BITS + TA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);

  mdio_state_t      state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [31:0]      tx_sr_reg, tx_sr_next;
  logic [15:0]      rx_sr_reg, rx_sr_next;
  logic [15:0]      rd_data_reg, rd_data_next;
  logic             is_read_reg, is_read_next;
  logic             boot_reg, boot_next;

  logic run, mdc, fall_en, rise_en;
  logic mdio_out, mdio_oe;

  assign run = (state_reg == S_PREAMBLE) || (state_reg == S_HEADER) ||
               (state_reg == S_TURNAROUND) || (state_reg == S_DATA);

  mdio_clkgen #(.MDC_HALF(MDC_HALF)) u_clkgen (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .mdc     (mdc),
    .fall_en (fall_en),
    .rise_en (rise_en)
  );

  // Output bit: preamble ones, otherwise the MSB of the header/data shift register.
  // Reads release the line from the turnaround onwards so the PHY can drive it.
  assign mdio_out = (state_reg == S_PREAMBLE) ? 1'b1 : tx_sr_reg[31];
  assign mdio_oe  = (state_reg == S_PREAMBLE) || (state_reg == S_HEADER) ||
                    (((state_reg == S_TURNAROUND) || (state_reg == S_DATA)) && !is_read_reg);
  assign mdio_pin = mdio_oe ? mdio_out : 1'bz;

  assign mdc_pin = mdc;
  assign ready   = (state_reg == S_DONE);
  assign rd_data = rd_data_reg;

  // State and datapath registers; async reset aborts any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= '0;
      tx_sr_reg   <= '0;
      rx_sr_reg   <= '0;
      rd_data_reg <= '0;
      is_read_reg <= 1'b0;
      boot_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_sr_reg   <= tx_sr_next;
      rx_sr_reg   <= rx_sr_next;
      rd_data_reg <= rd_data_next;
      is_read_reg <= is_read_next;
      boot_reg    <= boot_next;
    end
  end

  // Next-state: acceptance in IDLE/DONE, bit advance on MDC fall, read sampling on MDC rise.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_sr_next   = tx_sr_reg;
    rx_sr_next   = rx_sr_reg;
    rd_data_next = rd_data_reg;
    is_read_next = is_read_reg;
    boot_next    = boot_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (boot_reg) begin
          // First edge out of reset announces the engine as available.
          state_next = S_DONE;
          boot_next  = 1'b0;
        end else if (rd_request || wr_request) begin
          state_next   = S_PREAMBLE;
          bit_cnt_next = '0;
          is_read_next = rd_request;
          tx_sr_next   = {ST, (rd_request ? OP_READ : OP_WRITE), PHY_ADDR, addr, TA_WR, wr_data};
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        if (rise_en && (state_reg == S_DATA) && is_read_reg) begin
          rx_sr_next = {rx_sr_reg[14:0], mdio_pin};
        end
        if (fall_en) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (state_reg != S_PREAMBLE) begin
            tx_sr_next = {tx_sr_reg[30:0], 1'b0};
          end
          case (state_reg)
            S_PREAMBLE:   if (bit_cnt_reg == LAST_PRE) state_next = S_HEADER;
            S_HEADER:     if (bit_cnt_reg == LAST_HDR) state_next = S_TURNAROUND;
            S_TURNAROUND: if (bit_cnt_reg == LAST_TA)  state_next = S_DATA;
            S_DATA: begin
              if (bit_cnt_reg == LAST_BIT) begin
                state_next   = S_DONE;
                bit_cnt_next = bit_cnt_reg;
                if (is_read_reg) begin
                  rd_data_next = rx_sr_reg;
                end
              end
            end
            default: state_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

endmodule
